// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Multi-cycle control unit for the single-core processor. It fetches 20-bit
// instructions addressed by the external PC register, latches them into its
// own IR and steps FETCH -> DECODE -> EXEC -> (MEM) -> FETCH. A HALT state
// freezes the core until reset.
//
// The PC register downstream loads pc_next on every clock with no enable.
// pc_next therefore always carries a value: pc_cur to hold, pc_cur + 1 in
// FETCH, or a jump/trap target in EXEC. While rst is high it is forced to 0.
//
// Optional feature (compile-time macro CONTROL_SEQUENCER_ILLEGAL_TRAP_EN):
//   defined   - an illegal opcode (A..E) in EXEC loads TRAP_VECTOR into the PC
//               and sets the sticky trap flag, which holds until rst.
//   undefined - illegal opcodes execute as NOP and trap is tied 0.
//
// Ports:
//   clk       in   1         system clock, rising edge
//   rst       in   1         asynchronous reset, active-high
//   instr     in   20        instruction memory data for address pc_cur
//   pc_cur    in   PC_WIDTH  current PC register output
//   z_flag    in   1         datapath zero flag, only looked at in EXEC
//   pc_next   out  PC_WIDTH  PC register din
//   ir        out  20        latched instruction
//   ar_load   out  1         AR loads ar_value on this clock
//   ar_value  out  AR_WIDTH  operand field ir[11:0]
//   alu_op    out  4         opcode during EXEC, else 0
//   acc_we    out  1         accumulator write strobe
//   dram_we   out  1         data RAM write strobe
//   halted    out  1         core is in HALT
//   trap      out  1         sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int                   PC_WIDTH    = 6,
  parameter int                   AR_WIDTH    = 12,
  parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR = 6'd62
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [19:0]          instr,
  input  logic [PC_WIDTH-1:0]  pc_cur,
  input  logic                 z_flag,
  output logic [PC_WIDTH-1:0]  pc_next,
  output logic [19:0]          ir,
  output logic                 ar_load,
  output logic [AR_WIDTH-1:0]  ar_value,
  output logic [3:0]           alu_op,
  output logic                 acc_we,
  output logic                 dram_we,
  output logic                 halted,
  output logic                 trap
);

  // Opcode map
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t       state_reg, state_next;
  logic [19:0]  ir_reg;

  // Decoded fields of the registered instruction
  logic [3:0]           opcode;
  logic [PC_WIDTH-1:0]  jump_target;
  logic                 is_mem_op;
  logic                 is_alu_op;
  logic                 is_illegal;

  assign opcode      = ir_reg[19:16];
  assign jump_target = ir_reg[PC_WIDTH-1:0];
  assign is_mem_op   = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign is_alu_op   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                       (opcode == OP_AND) || (opcode == OP_OR);
  // Everything between JNZ and HALT (A..E) is unassigned.
  assign is_illegal  = (opcode > OP_JNZ) && (opcode != OP_HALT);

  // ---------------------------------------------------------------------------
  // State and instruction registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_FETCH;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_FETCH) begin
        ir_reg <= instr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Illegal-opcode trap flag
  // ---------------------------------------------------------------------------
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  logic trap_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_reg <= 1'b0;
    end else if (state_reg == ST_EXEC && is_illegal) begin
      trap_reg <= 1'b1;
    end
  end

  assign trap = trap_reg;
`else
  assign trap = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next state, PC steering and Moore strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_cur;      // the free-loading PC holds unless told otherwise
    ar_load    = 1'b0;
    alu_op     = 4'h0;
    acc_we     = 1'b0;
    dram_we    = 1'b0;
    halted     = 1'b0;

    unique case (state_reg)
      ST_FETCH: begin
        pc_next    = pc_cur + PC_WIDTH'(1);   // wraps naturally at 2^PC_WIDTH
        state_next = ST_DECODE;
      end

      ST_DECODE: begin
        ar_load    = is_mem_op;
        state_next = ST_EXEC;
      end

      ST_EXEC: begin
        alu_op     = opcode;
        state_next = ST_FETCH;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: acc_we = 1'b1;
          OP_JMP:                        pc_next = jump_target;
          OP_JZ:   if (z_flag)           pc_next = jump_target;
          OP_JNZ:  if (!z_flag)          pc_next = jump_target;
          OP_LOAD, OP_STORE:             state_next = ST_MEM;
          OP_HALT:                       state_next = ST_HALT;
          default: begin
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
            if (is_illegal) begin
              pc_next = TRAP_VECTOR;
            end
`endif
          end
        endcase
      end

      ST_MEM: begin
        acc_we     = (opcode == OP_LOAD);
        dram_we    = (opcode == OP_STORE);
        state_next = ST_FETCH;
      end

      ST_HALT: begin
        halted     = 1'b1;
        state_next = ST_HALT;
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase

    // Reset parks the PC at 0 on every edge it covers.
    if (rst) begin
      pc_next = '0;
    end
  end

  assign ir       = ir_reg;
  assign ar_value = ir_reg[AR_WIDTH-1:0];

  // is_alu_op documents the accumulator-writing group alongside the case above
  // and is kept for readability of waveforms.
  logic unused_alu_flag;
  assign unused_alu_flag = is_alu_op & 1'b0;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Drives control_sequencer with an external PC register and a 64-word
// instruction memory. An instruction-level reference model (expected PC,
// expected per-cycle strobes derived from the opcode) is checked every cycle.
// Directed steps follow the test plan, then a randomized program runs.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] instr;
  logic [5:0]  pc_cur;
  logic        z_flag;
  logic [5:0]  pc_next;
  logic [19:0] ir;
  logic        ar_load;
  logic [11:0] ar_value;
  logic [3:0]  alu_op;
  logic        acc_we;
  logic        dram_we;
  logic        halted;
  logic        trap;

  logic [19:0] imem [64];

  int n_vec = 0;
  int n_bad = 0;

  logic [5:0] pc_m;
  logic       trap_m;

`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  control_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .pc_cur   (pc_cur),
    .z_flag   (z_flag),
    .pc_next  (pc_next),
    .ir       (ir),
    .ar_load  (ar_load),
    .ar_value (ar_value),
    .alu_op   (alu_op),
    .acc_we   (acc_we),
    .dram_we  (dram_we),
    .halted   (halted),
    .trap     (trap)
  );

  always #5 clk = ~clk;

  // Free-loading PC register and combinational instruction memory
  always @(posedge clk) pc_cur <= pc_next;
  assign instr = imem[pc_cur];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one instruction from FETCH, checking every cycle against the model.
  // zsel: 0/1 forces z_flag in EXEC, 2 picks it randomly. In DECODE z_flag is
  // driven to the opposite value to show it is ignored there.
  task automatic run_instr(input int zsel, output bit did_halt);
    logic [19:0] w;
    logic [3:0]  op;
    logic [5:0]  tgt, exp_pc, pc_inc;
    bit          ldst, alu, illegal, ze;

    w       = imem[pc_m];
    op      = w[19:16];
    tgt     = w[5:0];
    ldst    = (op == 4'h1) || (op == 4'h2);
    alu     = (op >= 4'h3) && (op <= 4'h6);
    illegal = (op >= 4'hA) && (op <= 4'hE);
    ze      = (zsel == 2) ? 1'($urandom % 2) : (zsel == 1);
    did_halt = 1'b0;

    // FETCH
    z_flag = 1'($urandom % 2);
    #1;
    pc_inc = pc_m + 6'd1;
    check("fetch_pc_cur", pc_cur, pc_m);
    check("fetch_pc_next", pc_next, pc_inc);
    check("fetch_strobes", {ar_load, acc_we, dram_we, alu_op, halted}, 8'd0);
    check("fetch_trap", trap, trap_m);
    tick;
    pc_m = pc_inc;

    // DECODE
    z_flag = ~ze;
    #1;
    check("decode_ir", ir, w);
    check("decode_ar_load", ar_load, ldst);
    check("decode_ar_value", ar_value, w[11:0]);
    check("decode_strobes", {acc_we, dram_we, alu_op, halted}, 7'd0);
    check("decode_pc_next", pc_next, pc_m);
    tick;

    // EXEC
    z_flag = ze;
    #1;
    case (op)
      4'h7:    exp_pc = tgt;
      4'h8:    exp_pc = ze ? tgt : pc_m;
      4'h9:    exp_pc = ze ? pc_m : tgt;
      default: exp_pc = (illegal && TRAP_ON) ? 6'd62 : pc_m;
    endcase
    check("exec_pc_next", pc_next, exp_pc);
    check("exec_alu_op", alu_op, op);
    check("exec_acc_we", acc_we, alu);
    check("exec_other", {ar_load, dram_we, halted}, 3'd0);
    tick;
    pc_m = exp_pc;
    if (illegal && TRAP_ON) trap_m = 1'b1;
    check("exec_trap_after", trap, trap_m);

    if (op == 4'hF) begin
      did_halt = 1'b1;
    end else if (ldst) begin
      // MEM
      z_flag = 1'($urandom % 2);
      #1;
      check("mem_acc_we", acc_we, op == 4'h1);
      check("mem_dram_we", dram_we, op == 4'h2);
      check("mem_other", {ar_load, alu_op, halted}, 6'd0);
      check("mem_pc_next", pc_next, pc_m);
      tick;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #1;
    check("rst_pc_next", pc_next, 6'd0);
    check("rst_outputs", {ir, ar_load, acc_we, dram_we, alu_op, halted, trap}, 29'd0);
    tick;
    tick;
    check("rst_pc_cur", pc_cur, 6'd0);
    rst    = 1'b0;
    pc_m   = 6'd0;
    trap_m = 1'b0;
  endtask

  initial begin
    bit h;
    rst    = 1'b1;
    z_flag = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 20'h00000;

    // ---- Directed program ----
    imem[3]  = 20'hB0123;   // illegal opcode
    imem[4]  = 20'h202A5;   // STORE 0x2A5
    imem[5]  = 20'h80014;   // JZ 20
    imem[20] = 20'h70005;   // JMP 5
    imem[6]  = 20'h7003F;   // JMP 63
    imem[62] = 20'h70004;   // JMP 4 (trap landing)
    do_reset;

    for (int i = 0; i < 3; i++) run_instr(2, h);       // NOPs at 0,1,2
    #1 check("linear_pc", pc_cur, 6'd3);
    run_instr(2, h);                                   // illegal at 3
    #1 check("illegal_pc", pc_cur, TRAP_ON ? 6'd62 : 6'd4);
    check("illegal_trap", trap, TRAP_ON);
    if (TRAP_ON) run_instr(2, h);                      // JMP 4 from 62
    run_instr(2, h);                                   // STORE at 4
    #1 check("store_next_pc", pc_cur, 6'd5);
    run_instr(1, h);                                   // JZ taken
    #1 check("jz_taken_pc", pc_cur, 6'd20);
    run_instr(2, h);                                   // JMP 5
    run_instr(0, h);                                   // JZ not taken
    #1 check("jz_not_taken_pc", pc_cur, 6'd6);
    run_instr(2, h);                                   // JMP 63
    run_instr(2, h);                                   // NOP at 63 wraps
    #1 check("wrap_pc", pc_cur, 6'd0);
    check("trap_sticky", trap, TRAP_ON);

    // ---- HALT and asynchronous reset out of it ----
    for (int i = 0; i < 64; i++) imem[i] = 20'h00000;
    imem[9] = 20'hF0000;
    do_reset;
    for (int i = 0; i < 10; i++) run_instr(2, h);
    check("halt_reached", h, 1'b1);
    for (int i = 0; i < 5; i++) begin
      z_flag = 1'($urandom % 2);
      #1;
      check("halt_flag", halted, 1'b1);
      check("halt_pc_cur", pc_cur, 6'd10);
      check("halt_pc_next", pc_next, 6'd10);
      check("halt_strobes", {ar_load, acc_we, dram_we, alu_op}, 7'd0);
      tick;
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_halted", halted, 1'b0);
    check("async_rst_pc_next", pc_next, 6'd0);
    check("async_rst_ir", ir, 20'd0);
    @(posedge clk);
    #1 check("async_rst_pc_cur", pc_cur, 6'd0);
    @(negedge clk);
    tick;
    rst    = 1'b0;
    pc_m   = 6'd0;
    trap_m = 1'b0;

    // ---- Randomized program (no HALT) ----
    for (int i = 0; i < 64; i++) begin
      logic [3:0]  rop;
      logic [15:0] rlo;
      rop = 4'($urandom_range(0, 14));
      rlo = 16'($urandom);
      imem[i] = {rop, rlo};
    end
    do_reset;
    for (int i = 0; i < 120; i++) run_instr(2, h);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
